// File: rtl/lza_norm_arb_if.sv
// Request/result bundle for the shared normalization unit: per-lane requests in,
// one registered result out. The DUT takes the slave view, lanes and consumer the master view.
interface lza_norm_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDW-1:0]       out_id;
  logic [5:0]           out_count;
  logic [31:0]          out_norm;
  logic                 out_zero;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_id, out_count, out_norm, out_zero
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_id, out_count, out_norm, out_zero
  );
endinterface

// File: rtl/lza_norm_arb.sv
// Round-robin arbiter feeding one 32-bit leading-zero counter and left shifter,
// with a single registered valid/ready result stage.
module lza_norm_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  lza_norm_arb_if.slave    bus
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           found;
  logic           load_en;
  logic           accept;
  logic [31:0]    operand;
  logic [3:0]     byte_cnt [4];
  logic [3:0]     byte_zero;
  logic [5:0]     lz_count;
  logic [31:0]    lz_norm;

  function automatic logic [3:0] lzc8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd8;
    // Ascending scan: the highest set bit is the last to write n.
    for (int i = 0; i < 8; i++) begin
      if (b[i]) n = 4'(7 - i);
    end
    return n;
  endfunction

  // NOTE: every output of a combinational block gets a default before any
  // conditional logic, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = IDW'((int'(ptr) + off) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // rst_n gates the grant so no lane sees a handshake while the unit is held in reset.
  assign load_en = !bus.out_valid || bus.out_ready;
  assign accept  = found && load_en && rst_n;
  assign ptr_nxt = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[winner] = 1'b1;
  end

  assign operand = bus.req_data[32*int'(winner) +: 32];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_cnt[k]  = lzc8(operand[8*k +: 8]);
      byte_zero[k] = (operand[8*k +: 8] == 8'h00);
    end
  end

  // Lower bytes contribute only while every byte above them is zero.
  always_comb begin
    lz_count = 6'(byte_cnt[3]);
    if (byte_zero[3]) begin
      lz_count = lz_count + 6'(byte_cnt[2]);
      if (byte_zero[2]) begin
        lz_count = lz_count + 6'(byte_cnt[1]);
        if (byte_zero[1]) lz_count = lz_count + 6'(byte_cnt[0]);
      end
    end
  end

  assign lz_norm = operand << lz_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_id    <= '0;
      bus.out_count <= '0;
      bus.out_norm  <= '0;
      bus.out_zero  <= 1'b0;
    end else if (accept) begin
      ptr           <= ptr_nxt;
      bus.out_valid <= 1'b1;
      bus.out_id    <= winner;
      bus.out_count <= lz_count;
      bus.out_norm  <= lz_norm;
      bus.out_zero  <= (lz_count == 6'd32);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lza_norm_arb.sv
// Directed bench for lza_norm_arb: reset, edge operands, fairness,
// backpressure, pointer wrap and asynchronous reset mid-stream.
module tb_lza_norm_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errs   = 0;

  lza_norm_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  lza_norm_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [31:0] d);
    bus.req_data[32*lane +: 32] = d;
  endtask

  task automatic check_out(input string tag, input logic [1:0] id,
                           input logic [5:0] cnt, input logic [31:0] norm, input logic zero);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".id"},    32'(bus.out_id),    32'(id));
    check({tag, ".count"}, 32'(bus.out_count), 32'(cnt));
    check({tag, ".norm"},  bus.out_norm,       norm);
    check({tag, ".zero"},  32'(bus.out_zero),  32'(zero));
  endtask

  logic [31:0] edge_in   [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h00FF_0000};
  logic [5:0]  edge_cnt  [4] = '{6'd0, 6'd31, 6'd32, 6'd8};
  logic [31:0] edge_norm [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFF00_0000};
  logic [1:0]  fair_all  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0]  fair_skip [6] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst.valid",  32'(bus.out_valid), 32'd0);
    check("rst.ready",  32'(bus.req_ready), 32'd0);
    check("rst.count",  32'(bus.out_count), 32'd0);
    check("rst.norm",   bus.out_norm,       32'd0);
    check("rst.id",     32'(bus.out_id),    32'd0);
    bus.req_valid = '0;
    step();
    rst_n = 1'b1;

    // Single request from lane 2
    set_lane(2, 32'h0001_0000);
    bus.req_valid = 4'b0100;
    #1 check("single.ready", 32'(bus.req_ready), 32'b0100);
    step();
    check_out("single", 2'd2, 6'd15, 32'h8000_0000, 1'b0);

    // Edge operands back-to-back from lane 0
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      set_lane(0, edge_in[i]);
      step();
      check_out($sformatf("edge%0d", i), 2'd0, edge_cnt[i], edge_norm[i], edge_cnt[i] == 6'd32);
    end

    // Grant lane 3 once so the pointer returns to 0
    bus.req_valid = 4'b1000;
    step();
    check("align.id", 32'(bus.out_id), 32'd3);

    // Fairness with all lanes, then with lane 1 dropped
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("fair%0d.id", i), 32'(bus.out_id), 32'(fair_all[i]));
      check($sformatf("fair%0d.valid", i), 32'(bus.out_valid), 32'd1);
    end
    bus.req_valid = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("skip%0d.id", i), 32'(bus.out_id), 32'(fair_skip[i]));
    end
    bus.req_valid = '0;
    step();
    check("drain.valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: lanes 0 and 3 valid, consumer stalls for 5 cycles
    set_lane(0, 32'h0000_0100);
    set_lane(3, 32'h4000_0000);
    bus.req_valid = 4'b1001;
    #1 check("bp.first_ready", 32'(bus.req_ready), 32'b0001);
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("bp%0d.ready", i), 32'(bus.req_ready), 32'd0);
      step();
      check_out($sformatf("bp%0d", i), 2'd0, 6'd23, 32'h8000_0000, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1 check("bp.release_ready", 32'(bus.req_ready), 32'b1000);
    check("bp.release_valid", 32'(bus.out_valid), 32'd1);
    check("bp.release_id",    32'(bus.out_id),    32'd0);
    step();
    check_out("bp.next", 2'd3, 6'd1, 32'h8000_0000, 1'b0);

    // Wrap and skip: grant lane 2 (ptr -> 3), then only lane 1 valid
    set_lane(2, 32'h0000_0010);
    bus.req_valid = 4'b0100;
    step();
    check("wrap.id2", 32'(bus.out_id), 32'd2);
    bus.req_valid = 4'b0010;
    #1 check("wrap.ready1", 32'(bus.req_ready), 32'b0010);
    step();
    check("wrap.id1", 32'(bus.out_id), 32'd1);
    bus.req_valid = 4'b1111;
    #1 check("wrap.ptr2", 32'(bus.req_ready), 32'b0100);
    step();
    check("pre_rst.valid", 32'(bus.out_valid), 32'd1);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(bus.out_valid), 32'd0);
    check("arst.count", 32'(bus.out_count), 32'd0);
    check("arst.ready", 32'(bus.req_ready), 32'd0);
    step();
    check("arst.hold_valid", 32'(bus.out_valid), 32'd0);
    #2 rst_n = 1'b1;
    #1 check("arst.first_ready", 32'(bus.req_ready), 32'b0001);
    step();
    check("arst.first_id", 32'(bus.out_id), 32'd0);
    check("arst.first_valid", 32'(bus.out_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end
endmodule
